mem_wb_rf: RTL and testbench

MEM_WB_RF -- requirements
Module: mem_wb_rf

---
 rtl/mem_wb_rf_pkg.sv | 27 ++
 rtl/mem_wb_rf_regfile.sv | 58 +++++
 rtl/mem_wb_rf.sv | 64 ++++++
 tb/tb_mem_wb_rf.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_rf_pkg.sv
// Shared widths, constants and WB payload type for the MEM/WB latch and register file.
package mem_wb_rf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_NUM    = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]      reg_word_t;

    localparam reg_addr_t NOP_REG_ADDR  = '0;
    localparam reg_word_t ZERO_WORD     = '0;
    localparam logic      WRITE_ENABLE  = 1'b1;
    localparam logic      WRITE_DISABLE = 1'b0;
    localparam logic      READ_ENABLE   = 1'b1;
    localparam logic      READ_DISABLE  = 1'b0;
    localparam logic      RST_ENABLE    = 1'b0;

    typedef struct packed {
        reg_addr_t wd;
        logic      wreg;
        reg_word_t wdata;
    } wb_payload_t;

    localparam wb_payload_t WB_BUBBLE = '{wd: NOP_REG_ADDR, wreg: WRITE_DISABLE, wdata: ZERO_WORD};

endpackage

// File: rtl/mem_wb_rf_regfile.sv
// 32x32 register file, r0 hardwired to zero, two combinational read ports.
// Define MEM_WB_RF_BYPASS_EN to forward the in-flight write onto the read ports.
module regfile
    import mem_wb_rf_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  reg_addr_t waddr,
    input  reg_word_t wdata,
    input  logic      re1,
    input  reg_addr_t raddr1,
    input  logic      re2,
    input  reg_addr_t raddr2,
    output reg_word_t rdata1_c,
    output reg_word_t rdata2_c
);

    reg_word_t regs [REG_NUM];

    // Write port; r0 is never updated
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs[i] <= ZERO_WORD;
            end
        end else if ((we == WRITE_ENABLE) && (waddr != NOP_REG_ADDR)) begin
            regs[waddr] <= wdata;
        end
    end

    function automatic reg_word_t read_port(input logic re, input reg_addr_t raddr);
        reg_word_t rd;
        rd = ZERO_WORD;
        case (re)
            READ_ENABLE: begin
                if (raddr != NOP_REG_ADDR) begin
`ifdef MEM_WB_RF_BYPASS_EN
                    rd = ((we == WRITE_ENABLE) && (waddr == raddr)) ? wdata : regs[raddr];
`else
                    rd = regs[raddr];
`endif
                end
            end
            READ_DISABLE: rd = ZERO_WORD;
            default:      rd = ZERO_WORD;
        endcase
        return rd;
    endfunction

    always_comb begin
        rdata1_c = ZERO_WORD;
        rdata2_c = ZERO_WORD;
        rdata1_c = read_port(re1, raddr1);
        rdata2_c = read_port(re2, raddr2);
    end

endmodule

// File: rtl/mem_wb_rf.sv
// MEM/WB pipeline latch, retired-write counter and register file.
// Optional write-to-read forwarding inside regfile via MEM_WB_RF_BYPASS_EN.
module mem_wb_rf
    import mem_wb_rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      wdata_i,
    output logic [REG_ADDR_W-1:0] wb_wd_o,
    output logic                  wb_wreg_o,
    output logic [REG_W-1:0]      wb_wdata_o,
    input  logic                  re1_i,
    input  logic                  re2_i,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic [REG_W-1:0]      rdata1_o,
    output logic [REG_W-1:0]      rdata2_o,
    output logic [REG_W-1:0]      instret_o
);

    wb_payload_t wb_q;
    reg_word_t   instret_q;

    // A stalled or flushed MEM stage hands WB a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            wb_q      <= WB_BUBBLE;
            instret_q <= ZERO_WORD;
        end else begin
            if (stall_i || flush_i) begin
                wb_q <= WB_BUBBLE;
            end else begin
                wb_q <= '{wd: wd_i, wreg: wreg_i, wdata: wdata_i};
            end
            if (wb_q.wreg == WRITE_ENABLE) begin
                instret_q <= instret_q + REG_W'(1);
            end
        end
    end

    assign wb_wd_o    = wb_q.wd;
    assign wb_wreg_o  = wb_q.wreg;
    assign wb_wdata_o = wb_q.wdata;
    assign instret_o  = instret_q;

    regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_q.wreg),
        .waddr    (wb_q.wd),
        .wdata    (wb_q.wdata),
        .re1      (re1_i),
        .raddr1   (raddr1_i),
        .re2      (re2_i),
        .raddr2   (raddr2_i),
        .rdata1_c (rdata1_o),
        .rdata2_c (rdata2_o)
    );

endmodule

// File: tb/tb_mem_wb_rf.sv
// Testbench for mem_wb_rf: directed scenarios plus random traffic against a reference model.
// Honours MEM_WB_RF_BYPASS_EN in its expectations.
module tb_mem_wb_rf;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;
    logic        re1_i, re2_i;
    logic [4:0]  raddr1_i, raddr2_i;
    logic [31:0] rdata1_o, rdata2_o;
    logic [31:0] instret_o;

    mem_wb_rf dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .wb_wd_o    (wb_wd_o),
        .wb_wreg_o  (wb_wreg_o),
        .wb_wdata_o (wb_wdata_o),
        .re1_i      (re1_i),
        .re2_i      (re2_i),
        .raddr1_i   (raddr1_i),
        .raddr2_i   (raddr2_i),
        .rdata1_o   (rdata1_o),
        .rdata2_o   (rdata2_o),
        .instret_o  (instret_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: architectural registers, the pending WB write and the retire count
    logic [31:0] m_regs [32];
    logic [4:0]  m_wd;
    logic        m_wreg;
    logic [31:0] m_wdata;
    logic [31:0] m_instret;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_wd = 5'h0; m_wreg = 1'b0; m_wdata = 32'h0; m_instret = 32'h0;
    endtask

    function automatic logic [31:0] model_read(input logic re, input logic [4:0] a);
        if (!re || a == 5'd0) return 32'h0;
`ifdef MEM_WB_RF_BYPASS_EN
        if (m_wreg && m_wd == a) return m_wdata;
`endif
        return m_regs[a];
    endfunction

    task automatic model_edge();
        if (m_wreg && m_wd != 5'd0) m_regs[m_wd] = m_wdata;
        if (m_wreg) m_instret = m_instret + 32'd1;
        if (stall_i || flush_i) begin
            m_wd = 5'h0; m_wreg = 1'b0; m_wdata = 32'h0;
        end else begin
            m_wd = wd_i; m_wreg = wreg_i; m_wdata = wdata_i;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".wb_wd"},    32'(wb_wd_o),   32'(m_wd));
        check({tag, ".wb_wreg"},  32'(wb_wreg_o), 32'(m_wreg));
        check({tag, ".wb_wdata"}, wb_wdata_o,     m_wdata);
        check({tag, ".instret"},  instret_o,      m_instret);
        check({tag, ".rdata1"},   rdata1_o,       model_read(re1_i, raddr1_i));
        check({tag, ".rdata2"},   rdata2_o,       model_read(re2_i, raddr2_i));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic [4:0] wd, input logic wr, input logic [31:0] d,
                         input logic st, input logic fl);
        wd_i = wd; wreg_i = wr; wdata_i = d; stall_i = st; flush_i = fl;
    endtask

    task automatic read(input logic [4:0] a1, input logic [4:0] a2);
        re1_i = 1'b1; raddr1_i = a1; re2_i = 1'b1; raddr2_i = a2;
    endtask

    logic [31:0] exp_bypass;
    logic [31:0] cnt_before;

    initial begin
        rst = 1'b0;
        drive(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        re1_i = 1'b0; re2_i = 1'b0; raddr1_i = 5'd0; raddr2_i = 5'd0;
        model_reset();
        #1;
        check("rst.wb_wreg", 32'(wb_wreg_o), 32'h0);
        check("rst.wb_wdata", wb_wdata_o, 32'h0);
        check("rst.instret", instret_o, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic write of r5
        drive(5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        read(5'd5, 5'd5);
        tick("basic.e1");
        check("basic.wb_wdata_e1", wb_wdata_o, 32'hDEADBEEF);
        check("basic.wb_wd_e1", 32'(wb_wd_o), 32'd5);
        drive(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick("basic.e2");
        check("basic.r5", rdata1_o, 32'hDEADBEEF);
        check("basic.instret", instret_o, 32'd1);

        // r0 protection still counts as a retired write
        drive(5'd0, 1'b1, 32'h12345678, 1'b0, 1'b0);
        read(5'd0, 5'd0);
        tick("r0.e1");
        drive(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick("r0.e2");
        check("r0.read", rdata1_o, 32'h0);
        check("r0.instret", instret_o, 32'd2);

        // Same-cycle read of the register being written
        drive(5'd7, 1'b1, 32'h1, 1'b0, 1'b0);
        read(5'd7, 5'd7);
        tick("byp.w1");
        drive(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick("byp.c1");
        drive(5'd7, 1'b1, 32'h2, 1'b0, 1'b0);
        tick("byp.w2");
`ifdef MEM_WB_RF_BYPASS_EN
        exp_bypass = 32'h2;
`else
        exp_bypass = 32'h1;
`endif
        check("byp.same_cycle1", rdata1_o, exp_bypass);
        check("byp.same_cycle2", rdata2_o, exp_bypass);
        drive(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick("byp.c2");
        check("byp.next_cycle", rdata1_o, 32'h2);

        // Stall, flush and both each yield a bubble
        read(5'd9, 5'd9);
        for (int k = 1; k <= 3; k++) begin
            cnt_before = instret_o;
            drive(5'd9, 1'b1, 32'hA5A50000 + 32'(k), k[0], k[1]);
            tick("sf.e1");
            check("sf.wb_wreg", 32'(wb_wreg_o), 32'h0);
            drive(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
            tick("sf.e2");
            check("sf.r9", rdata1_o, 32'h0);
            check("sf.instret", instret_o, cnt_before);
        end

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive(5'($urandom), ($urandom_range(0, 3) != 0), $urandom,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            re1_i = ($urandom_range(0, 7) != 0); raddr1_i = 5'($urandom);
            re2_i = ($urandom_range(0, 7) != 0);
            raddr2_i = ($urandom_range(0, 3) == 0) ? wd_i : 5'($urandom);
            tick("rand");
        end

        // Asynchronous reset with a write pending in WB
        drive(5'd3, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
        read(5'd3, 5'd3);
        tick("arst.load");
        check("arst.pending", 32'(wb_wreg_o), 32'h1);
        drive(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check("arst.wb_wreg", 32'(wb_wreg_o), 32'h0);
        check("arst.wb_wd", 32'(wb_wd_o), 32'h0);
        check("arst.wb_wdata", wb_wdata_o, 32'h0);
        check("arst.instret", instret_o, 32'h0);
        for (int i = 1; i < 32; i++) begin
            raddr1_i = 5'(i);
            #1;
            check("arst.reg", rdata1_o, 32'h0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        read(5'd3, 5'd3);
        tick("arst.after");
        check("arst.r3_lost", rdata1_o, 32'h0);

        // Counter wrap from a forced 0xFFFFFFFF
        drive(5'd4, 1'b1, 32'h44, 1'b0, 1'b0);
        tick("wrap.load");
        drive(5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        m_instret = 32'hFFFF_FFFF;
        #1;
        check("wrap.preset", instret_o, 32'hFFFF_FFFF);
        tick("wrap.edge");
        check("wrap.zero", instret_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
